uart_fsm: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx.sv | 85 ++++++++
 rtl/uart_fsm.sv | 155 +++++++++++++++
 tb/tb_uart_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FSM and its echo transmitter.
// Frame format is 8 data bits, no parity, 2 stop bits, LSB first.
package uart_pkg;

   localparam int DEFAULT_CLK_FREQ  = 50_000_000;
   localparam int DEFAULT_BAUD_RATE = 115_200;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 2;
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP1 = 3'd3,
      RX_STOP2 = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_tx.sv
// Echo transmitter: one-entry pending register feeding an 8N2 serialiser.
// A byte arriving while the pending slot is full replaces it (newest wins).
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 byte_valid,
   input  logic [DATA_BITS-1:0] byte_in,
   output logic                 tx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(FRAME_BITS);

   logic [DATA_BITS-1:0]  pend_q, pend_d;
   logic                  pend_full_q, pend_full_d;
   logic                  busy_q, busy_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_q     <= '1;
         bit_q       <= '0;
         cnt_q       <= '0;
      end else begin
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         busy_q      <= busy_d;
         frame_q     <= frame_d;
         bit_q       <= bit_d;
         cnt_q       <= cnt_d;
      end
   end

   // An idle engine grabs a fresh byte directly, bypassing the pending slot.
   always_comb begin
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      busy_d      = busy_q;
      frame_d     = frame_q;
      bit_d       = bit_q;
      cnt_d       = cnt_q;
      take        = !busy_q && (byte_valid || pend_full_q);

      if (busy_q) begin
         if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_d   = '0;
            frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
            if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
               busy_d = 1'b0;
            end else begin
               bit_d = bit_q + BIT_W'(1);
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (take) begin
         busy_d  = 1'b1;
         cnt_d   = '0;
         bit_d   = '0;
         frame_d = {{STOP_BITS{1'b1}}, (byte_valid ? byte_in : pend_q), 1'b0};
      end

      if (byte_valid && busy_q) begin
         pend_d      = byte_in;
         pend_full_d = 1'b1;
      end else if (take) begin
         pend_full_d = 1'b0;
      end
   end

   assign tx = busy_q ? frame_q[0] : 1'b1;

endmodule

// File: rtl/uart_fsm.sv
// UART 8N2 receiver with 2-FF synchroniser, mid-bit sampling and frame-error
// detection; every good byte is handed to the echo transmitter.
module uart_fsm
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
   parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_raw,
   output logic       tx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_error,
   output logic [2:0] rx_state
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   logic [1:0]           sync_q;
   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 stop1_ok_q, stop1_ok_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;

   // Both stages reset to the idle-high level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_raw};
      end
   end

   assign rx_s = sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RX_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         stop1_ok_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         stop1_ok_q <= stop1_ok_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      stop1_ok_d = stop1_ok_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;

      unique case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = RX_IDLE;
               end else begin
                  idx_d   = '0;
                  state_d = RX_DATA;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = RX_STOP1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_STOP1: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d      = '0;
               stop1_ok_d = rx_s;
               state_d    = RX_STOP2;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_STOP2: begin
            // Leaving at mid stop2 gives half a bit of slack for a back-to-back start.
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (stop1_ok_q && rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign frame_error = ferr_q;
   assign rx_state    = state_q;

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk       (clk),
      .rst       (rst),
      .byte_valid(valid_q),
      .byte_in   (data_q),
      .tx        (tx)
   );

endmodule

// File: tb/tb_uart_fsm.sv
// Scoreboard bench for uart_fsm: frames are pushed as expectations when sent,
// and independent monitors check the RX strobes and decode the echoed tx line.
`timescale 1ns/1ps
module tb_uart_fsm;

   // A faster line rate keeps the run short; all timing below scales from CPB.
   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 500_000;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int HALF     = CPB / 2;
   localparam int LAT      = 2 + HALF + 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_raw = 1'b1;
   logic       tx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_error;
   logic [2:0] rx_state;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         start_cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] echo_q[$];
   logic [7:0] last_good = 8'h00;
   exp_t       mon_e;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;

   uart_fsm #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_raw     (rx_raw),
      .tx         (tx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_error(frame_error),
      .rx_state   (rx_state)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic driveBit(input logic v);
      rx_raw = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Sends one 8N2 frame and records what the receiver and echo should produce.
   task automatic applyStimulus(input logic [7:0] b, input bit s1, input bit s2);
      exp_t e;
      e.is_err    = !(s1 && s2);
      e.data      = e.is_err ? last_good : b;
      e.start_cyc = cyc;
      exp_q.push_back(e);
      if (!e.is_err) begin
         last_good = b;
         echo_q.push_back(b);
      end
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(b[i]);
      driveBit(s1);
      driveBit(s2);
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((exp_q.size() != 0 || echo_q.size() != 0) && n < 30000) begin
         @(posedge clk);
         n++;
      end
      #1;
      total++;
      if (n >= 30000) begin
         bad++;
         $display("[TB] FAIL drain_timeout: got %0d rx and %0d echo pending, expected 0", exp_q.size(), echo_q.size());
      end
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && (data_valid || frame_error)) begin
         checkOutput("strobe_exclusive", 32'(data_valid & frame_error), 32'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_strobe: got valid=%0b ferr=%0b, expected no strobe", data_valid, frame_error);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("strobe_kind_ferr", 32'(frame_error), 32'(mon_e.is_err));
            checkOutput("data_out", 32'(data_out), 32'(mon_e.data));
            total++;
            if ((cyc - mon_e.start_cyc) < LAT - 2 || (cyc - mon_e.start_cyc) > LAT + 2) begin
               bad++;
               $display("[TB] FAIL strobe_latency: got %0d cycles, expected %0d +/-2", cyc - mon_e.start_cyc, LAT);
            end
         end
      end
   end

   initial begin : echo_monitor
      logic [7:0] got;
      forever begin
         @(negedge tx);
         if (!rst) begin
            repeat (HALF) @(negedge clk);
            checkOutput("echo_start_bit", 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               got[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            checkOutput("echo_stop1", 32'(tx), 32'd1);
            repeat (CPB) @(negedge clk);
            checkOutput("echo_stop2", 32'(tx), 32'd1);
            if (echo_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_echo: got byte 0x%0h, expected no echo", got);
            end else begin
               checkOutput("echo_data", 32'(got), 32'(echo_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [7:0] seq [16];
      seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'hAA, 8'h55, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};

      rst    = 1'b1;
      rx_raw = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("reset_rx_state", 32'(rx_state), 32'd0);
      checkOutput("reset_tx", 32'(tx), 32'd1);
      checkOutput("reset_data_out", 32'(data_out), 32'd0);
      checkOutput("reset_valid", 32'(data_valid), 32'd0);
      checkOutput("reset_ferr", 32'(frame_error), 32'd0);

      for (int i = 0; i < 12; i++) applyStimulus(seq[i], 1'b1, 1'b1);
      waitDrain();

      // Error frame, then good frames immediately behind it.
      applyStimulus(8'hBD, 1'b0, 1'b1);
      for (int i = 12; i < 16; i++) applyStimulus(seq[i], 1'b1, 1'b1);
      waitDrain();

      rx_raw = 1'b0;
      repeat (HALF / 2) @(posedge clk);
      #1;
      rx_raw = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      #1;
      checkOutput("glitch_rx_state", 32'(rx_state), 32'd0);
      applyStimulus(8'h99, 1'b1, 1'b1);

      repeat (6) begin
         repeat ($urandom_range(0, 2) * CPB) @(posedge clk);
         #1;
         applyStimulus(8'($urandom), 1'b1, 1'b1);
      end
      waitDrain();

      driveBit(1'b0);
      driveBit(1'b1);
      driveBit(1'b0);
      checkOutput("mid_frame_rx_state", 32'(rx_state), 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("midreset_rx_state", 32'(rx_state), 32'd0);
      checkOutput("midreset_data_out", 32'(data_out), 32'd0);
      checkOutput("midreset_tx", 32'(tx), 32'd1);
      checkOutput("midreset_valid", 32'(data_valid), 32'd0);
      last_good = 8'h00;
      rx_raw    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2 * CPB) @(posedge clk);
      #1;
      applyStimulus(8'h3C, 1'b1, 1'b1);
      waitDrain();

      checkOutput("final_data_out", 32'(data_out), 32'h3C);
      checkOutput("final_rx_state", 32'(rx_state), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
